ex_stage_pipe: RTL and testbench
================================

// Module: ex_stage_pipe
// PURPOSE
//  Parametrised, registered execute stage for the pipelined CPU. Takes decoded operands,
//  performs ALU op (incl. iterative multi-cycle MUL), computes branch/JR target, produces
//  V/Z/N flags. Sits between ID/EX and EX/MEM; valid/ready handshake on both sides; flushable.
// PARAMETERS
//  DATA_W  16  datapath, PC and result width (>=8)
//  OFF_W   9   branch offset field width, sign-extended to DATA_W
//  SH_W    4   shift-amount width (2**SH_W >= DATA_W)
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  flush      in   1        kill in-flight op and output (mispredict/exception)
//  in_valid   in   1        operands valid
//  in_ready   out  1        stage can accept this cycle
//  in_pc      in   DATA_W   PC of instruction
//  in_src0    in   DATA_W   operand A (reg1)
//  in_reg2    in   DATA_W   register operand B
//  in_imm     in   DATA_W   sign-extended immediate
//  in_alu_src in   1        1: B=in_reg2, 0: B=in_imm
//  in_op      in   4        0 ADD,1 SUB,2 AND,3 NOR,4 SLL,5 SRL,6 SRA,8 MUL; others NOP
//  in_sh      in   SH_W     shift amount
//  in_off     in   OFF_W    branch offset
//  in_is_jr   in   1        target = ALU result
//  in_flags   in   3        current {N,Z,V}
//  out_valid  out  1        result registers valid
//  out_ready  in   1        downstream accepts
//  out_result out  DATA_W   ALU result
//  out_target out  DATA_W   branch/jump target
//  out_flags  out  3        {N,Z,V}
// BEHAVIOUR
//  Reset: out_valid=0, out_result=0, out_target=0, out_flags=0, FSM=IDLE, in_ready=1.
//  Accept when in_valid&in_ready. in_ready = (state==IDLE) & (~out_valid|out_ready) & ~flush.
//  Output held stable while out_valid&~out_ready; cleared when accepted with no new result.
//  FSM: IDLE -accept non-MUL-> IDLE, result registered, out_valid=1 next cycle (latency 1).
//       IDLE -accept MUL-> MUL; shift-add, 1 multiplier bit/cycle, DATA_W cycles;
//       MUL -count==DATA_W-1 and (~out_valid|out_ready)-> IDLE, out_valid=1 next cycle
//       (latency DATA_W+1); if output still blocked, stay in MUL with product held.
//  Arithmetic mod 2**DATA_W. ADD/SUB: update N,Z,V (V = signed overflow). AND/NOR/shifts:
//  update Z, N/V pass from in_flags. SLL/SRL logical, SRA arithmetic by in_sh; in_sh>=DATA_W
//  gives 0 (SRA: sign fill). MUL unsigned, low DATA_W bits; Z,N from low half, V=1 iff
//  upper half nonzero. NOP: result 0, flags = in_flags.
//  Target: in_is_jr ? result : in_pc + sext(in_off) + 1 (wraps). For MUL target computed
//  at accept and held.
//  flush: highest priority; next edge out_valid=0, FSM->IDLE, MUL aborted; in_valid ignored
//  that cycle. Async reset mid-MUL aborts identically.
// TESTING (DATA_W=16)
//  ADD 0x7FFF+0x0001, alu_src=1 -> 1 cycle later result 0x8000, flags N=1,Z=0,V=1.
//  SUB 5-5 then AND with in_flags N=1,V=1 -> Z=1,N=0,V=0; then Z=1,N=1,V=1 held.
//  SRA 0x8000 by 15 -> 0xFFFF; SLL 0x0001 by 15 -> 0x8000; in_sh=0 -> unchanged.
//  MUL 0x0100*0x0100 -> out_valid at accept+17, result 0x0000, Z=1, V=1; in_ready low meanwhile.
//  Branch pc=0x0010 off=9'h1FE -> target 0x000F; pc=0xFFFF off=0 -> 0x0000; JR src0=0x1234 ADD imm 0 -> 0x1234.
//  out_ready=0 for 3 cycles -> result stable, in_ready=0; flush mid-MUL -> out_valid stays 0, in_ready=1 next cycle.

Source files
------------

// File: rtl/ex_stage_pipe.sv
// Registered execute stage: single-cycle ALU, iterative shift-add multiplier, branch/JR target
// and {N,Z,V} flags, with valid/ready handshakes on both sides and a flush that kills in-flight work.
module ex_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int OFF_W  = 9,
    parameter int SH_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_src0,
    input  logic [DATA_W-1:0] in_reg2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_alu_src,
    input  logic [3:0]        in_op,
    input  logic [SH_W-1:0]   in_sh,
    input  logic [OFF_W-1:0]  in_off,
    input  logic              in_is_jr,
    input  logic [2:0]        in_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_target,
    output logic [2:0]        out_flags
);

    localparam int               CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_NOR = 4'd3,
        OP_SLL = 4'd4, OP_SRL = 4'd5, OP_SRA = 4'd6, OP_MUL = 4'd8
    } opCode_e;

    typedef enum logic {ST_IDLE, ST_MUL} state_e;

    state_e state, stateNext;

    logic [DATA_W-1:0]   opB, aluResult, branchTarget;
    logic [2:0]          aluFlags;
    logic                shOver, isMul, accept, outFree, mulLast, mulDone, mulStep;
    logic [2*DATA_W-1:0] mulAcc, mulCand, mulSum;
    logic [DATA_W-1:0]   mulPlier, mulTarget;
    logic                mulIsJr;
    logic [CNT_W-1:0]    mulCnt;

    assign opB          = in_alu_src ? in_reg2 : in_imm;
    assign shOver       = 32'(in_sh) >= 32'(DATA_W);
    assign branchTarget = in_pc + DATA_W'(signed'(in_off)) + DATA_W'(1);
    assign isMul        = (in_op == OP_MUL);
    assign outFree      = !out_valid || out_ready;
    assign in_ready     = (state == ST_IDLE) && outFree && !flush;
    assign accept       = in_valid && in_ready;

    // Last multiplier bit is folded in on the edge that registers the product, so a blocked
    // output simply freezes the partial state until downstream drains.
    assign mulLast = (state == ST_MUL) && (mulCnt == LAST_STEP);
    assign mulDone = mulLast && outFree;
    assign mulStep = (state == ST_MUL) && !(mulLast && !outFree);
    assign mulSum  = mulAcc + (mulPlier[0] ? mulCand : '0);

    always_comb begin
        // NOTE: defaults first so every path assigns aluResult/aluFlags and no latch is inferred.
        aluResult = '0;
        aluFlags  = in_flags;
        case (in_op)
            OP_ADD: begin
                aluResult = in_src0 + opB;
                aluFlags  = {aluResult[DATA_W-1], aluResult == '0,
                             (in_src0[DATA_W-1] == opB[DATA_W-1]) &&
                             (aluResult[DATA_W-1] != in_src0[DATA_W-1])};
            end
            OP_SUB: begin
                aluResult = in_src0 - opB;
                aluFlags  = {aluResult[DATA_W-1], aluResult == '0,
                             (in_src0[DATA_W-1] != opB[DATA_W-1]) &&
                             (aluResult[DATA_W-1] != in_src0[DATA_W-1])};
            end
            OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA: begin
                case (in_op)
                    OP_AND:  aluResult = in_src0 & opB;
                    OP_NOR:  aluResult = ~(in_src0 | opB);
                    OP_SLL:  aluResult = shOver ? '0 : (in_src0 << in_sh);
                    OP_SRL:  aluResult = shOver ? '0 : (in_src0 >> in_sh);
                    default: aluResult = shOver ? {DATA_W{in_src0[DATA_W-1]}}
                                                : $unsigned($signed(in_src0) >>> in_sh);
                endcase
                aluFlags = {in_flags[2], aluResult == '0, in_flags[0]};
            end
            default: begin
                aluResult = '0;
                aluFlags  = in_flags;
            end
        endcase
    end

    always_comb begin
        stateNext = state;
        if (flush) begin
            stateNext = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept && isMul) stateNext = ST_MUL;
                ST_MUL:  if (mulDone) stateNext = ST_IDLE;
                default: stateNext = ST_IDLE;
            endcase
        end
    end

    // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= stateNext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_target <= '0;
            out_flags  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept && !isMul) begin
            out_valid  <= 1'b1;
            out_result <= aluResult;
            out_flags  <= aluFlags;
            out_target <= in_is_jr ? aluResult : branchTarget;
        end else if (mulDone) begin
            out_valid  <= 1'b1;
            out_result <= mulSum[DATA_W-1:0];
            out_flags  <= {mulSum[DATA_W-1], mulSum[DATA_W-1:0] == '0,
                           |mulSum[2*DATA_W-1:DATA_W]};
            out_target <= mulIsJr ? mulSum[DATA_W-1:0] : mulTarget;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mulAcc    <= '0;
            mulCand   <= '0;
            mulPlier  <= '0;
            mulCnt    <= '0;
            mulTarget <= '0;
            mulIsJr   <= 1'b0;
        end else if (accept && isMul) begin
            mulAcc    <= '0;
            mulCand   <= {{DATA_W{1'b0}}, in_src0};
            mulPlier  <= opB;
            mulCnt    <= '0;
            mulTarget <= branchTarget;
            mulIsJr   <= in_is_jr;
        end else if (mulStep && !flush) begin
            mulAcc   <= mulSum;
            mulCand  <= mulCand << 1;
            mulPlier <= mulPlier >> 1;
            mulCnt   <= mulCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed vector table, hand-built handshake/flush/reset sequences,
// and a randomized run scored against a cycle-level transaction model of the stage.
module tb_ex_stage_pipe;

    localparam int DATA_W = 16;
    localparam int OFF_W  = 9;
    localparam int SH_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n, flush, in_valid, in_ready, in_alu_src, in_is_jr;
    logic [DATA_W-1:0] in_pc, in_src0, in_reg2, in_imm;
    logic [3:0]        in_op;
    logic [SH_W-1:0]   in_sh;
    logic [OFF_W-1:0]  in_off;
    logic [2:0]        in_flags, out_flags;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_result, out_target;

    always #5 clk = ~clk;

    ex_stage_pipe #(.DATA_W(DATA_W), .OFF_W(OFF_W), .SH_W(SH_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_src0(in_src0),
        .in_reg2(in_reg2), .in_imm(in_imm), .in_alu_src(in_alu_src), .in_op(in_op),
        .in_sh(in_sh), .in_off(in_off), .in_is_jr(in_is_jr), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_target(out_target), .out_flags(out_flags)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic setOp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        in_op = op; in_src0 = a; in_reg2 = b; in_imm = '0; in_alu_src = 1'b1;
        in_sh = '0; in_off = '0; in_pc = '0; in_is_jr = 1'b0; in_flags = '0;
    endtask

    task automatic doReset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        setOp(4'd0, 16'h0, 16'h0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    // Reference behaviour in plain integer arithmetic, {N,Z,V} flag order.
    function automatic void refExec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic [15:0] pc, input logic [3:0] sh, input logic [8:0] off,
                                    input logic jr, input logic [2:0] fin,
                                    output logic [15:0] res, output logic [2:0] fl, output logic [15:0] tgt);
        int sa, sb, wide, d, offInt;
        longint prod;
        sa = a[15] ? int'(a) - 65536 : int'(a);
        sb = b[15] ? int'(b) - 65536 : int'(b);
        d  = 1 << sh;
        res = '0;
        fl  = fin;
        case (op)
            4'd0, 4'd1: begin
                wide = (op == 4'd0) ? sa + sb : sa - sb;
                res  = 16'(wide);
                fl   = {res[15], res == 16'h0, (wide > 32767) || (wide < -32768)};
            end
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                case (op)
                    4'd2: res = a & b;
                    4'd3: res = ~(a | b);
                    4'd4: begin prod = longint'(a) * longint'(d); res = 16'(prod); end
                    4'd5: res = 16'(int'(a) / d);
                    default: begin
                        wide = sa / d;
                        if ((sa % d != 0) && (sa < 0)) wide = wide - 1;
                        res = 16'(wide);
                    end
                endcase
                fl = {fin[2], res == 16'h0, fin[0]};
            end
            4'd8: begin
                prod = longint'(a) * longint'(b);
                res  = 16'(prod);
                fl   = {res[15], res == 16'h0, prod > 65535};
            end
            default: begin
                res = '0;
                fl  = fin;
            end
        endcase
        offInt = off[8] ? int'(off) - 512 : int'(off);
        tgt = jr ? res : 16'(int'(pc) + offInt + 1);
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, reg2, imm, pc;
        logic        aluSrc;
        logic [3:0]  sh;
        logic [8:0]  off;
        logic        isJr;
        logic [2:0]  fin;
        logic [15:0] expRes;
        logic [2:0]  expFlags;
        logic [15:0] expTgt;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  opList[11];
        logic [15:0] corner[5];
        logic        mValid, pend;
        logic [15:0] mRes, mTgt, pRes, pTgt, rRes, rTgt, bOp;
        logic [2:0]  mFl, pFl, rFl;
        logic        expReady;
        int          busyEnd, pendAt, seen;

        //          op     a        reg2     imm      pc       src  sh    off     jr    fin     res      NZV     tgt      lat
        vecs[0]  = '{4'd0, 16'h7FFF, 16'h0001, 16'h0000, 16'h0010, 1'b1, 4'd0,  9'h1FE, 1'b0, 3'b000, 16'h8000, 3'b101, 16'h000F, 1};
        vecs[1]  = '{4'd1, 16'h0005, 16'h0005, 16'h0000, 16'hFFFF, 1'b1, 4'd0,  9'h000, 1'b0, 3'b000, 16'h0000, 3'b010, 16'h0000, 1};
        vecs[2]  = '{4'd2, 16'h00F0, 16'h0000, 16'h0F00, 16'h0100, 1'b0, 4'd0,  9'h000, 1'b0, 3'b101, 16'h0000, 3'b111, 16'h0101, 1};
        vecs[3]  = '{4'd6, 16'h8000, 16'h0000, 16'h0000, 16'h0100, 1'b1, 4'd15, 9'h000, 1'b0, 3'b000, 16'hFFFF, 3'b000, 16'h0101, 1};
        vecs[4]  = '{4'd4, 16'h0001, 16'h0000, 16'h0000, 16'h0100, 1'b1, 4'd15, 9'h000, 1'b0, 3'b001, 16'h8000, 3'b001, 16'h0101, 1};
        vecs[5]  = '{4'd4, 16'h1234, 16'h0000, 16'h0000, 16'h0100, 1'b1, 4'd0,  9'h000, 1'b0, 3'b000, 16'h1234, 3'b000, 16'h0101, 1};
        vecs[6]  = '{4'd0, 16'h1234, 16'hFFFF, 16'h0000, 16'h0100, 1'b0, 4'd0,  9'h000, 1'b1, 3'b000, 16'h1234, 3'b000, 16'h1234, 1};
        vecs[7]  = '{4'd3, 16'h0000, 16'h0000, 16'hFFFF, 16'h0100, 1'b0, 4'd0,  9'h000, 1'b0, 3'b100, 16'h0000, 3'b110, 16'h0101, 1};
        vecs[8]  = '{4'd7, 16'h1234, 16'h5678, 16'h0000, 16'h0100, 1'b1, 4'd0,  9'h000, 1'b0, 3'b011, 16'h0000, 3'b011, 16'h0101, 1};
        vecs[9]  = '{4'd5, 16'h8000, 16'h0000, 16'h0000, 16'h0100, 1'b1, 4'd4,  9'h000, 1'b0, 3'b010, 16'h0800, 3'b000, 16'h0101, 1};
        vecs[10] = '{4'd1, 16'h8000, 16'h0000, 16'h0001, 16'h0100, 1'b0, 4'd0,  9'h000, 1'b0, 3'b000, 16'h7FFF, 3'b001, 16'h0101, 1};
        vecs[11] = '{4'd8, 16'h0100, 16'h0100, 16'h0000, 16'h0020, 1'b1, 4'd0,  9'h003, 1'b0, 3'b000, 16'h0000, 3'b011, 16'h0024, 17};
        vecs[12] = '{4'd8, 16'h00FF, 16'h0000, 16'h0003, 16'h0100, 1'b0, 4'd0,  9'h000, 1'b0, 3'b111, 16'h02FD, 3'b000, 16'h0101, 17};
        vecs[13] = '{4'd6, 16'h4000, 16'h0000, 16'h0000, 16'h0100, 1'b1, 4'd15, 9'h000, 1'b0, 3'b101, 16'h0000, 3'b111, 16'h0101, 1};
        vecs[14] = '{4'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0100, 1'b1, 4'd0,  9'h000, 1'b0, 3'b000, 16'h0000, 3'b010, 16'h0101, 1};

        // Reset state, sampled while reset is held and again just after release.
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        setOp(4'd0, 16'h0, 16'h0);
        cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_target", 32'(out_target), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        cyc();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            int lat;
            cyc();
            in_op = vecs[i].op; in_src0 = vecs[i].a; in_reg2 = vecs[i].reg2; in_imm = vecs[i].imm;
            in_pc = vecs[i].pc; in_alu_src = vecs[i].aluSrc; in_sh = vecs[i].sh; in_off = vecs[i].off;
            in_is_jr = vecs[i].isJr; in_flags = vecs[i].fin; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            cyc();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 25) begin
                check($sformatf("vec%0d_busy_in_ready", i), 32'(in_ready), 32'd0);
                cyc();
                lat++;
            end
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_result", i), 32'(out_result), 32'(vecs[i].expRes));
            check($sformatf("vec%0d_flags", i), 32'(out_flags), 32'(vecs[i].expFlags));
            check($sformatf("vec%0d_target", i), 32'(out_target), 32'(vecs[i].expTgt));
        end

        // Backpressure: result held and input stalled for 3 cycles, then drain with overlap.
        cyc();
        setOp(4'd0, 16'h0003, 16'h0004); in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check("bp_first_accept", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (k == 0) setOp(4'd1, 16'h0010, 16'h0001);
            #1;
            check($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold_%0d", k), 32'(out_result), 32'h0007);
            check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd0);
        end
        cyc();
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_result", 32'(out_result), 32'h0007);
        cyc();
        in_valid = 1'b0;
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_result", 32'(out_result), 32'h000F);
        check("bp_second_flags", 32'(out_flags), 32'd0);
        cyc();
        check("bp_cleared", 32'(out_valid), 32'd0);

        // Flush in the middle of a multiply: no result, stage free next cycle.
        cyc();
        setOp(4'd8, 16'h0003, 16'h0005); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("fl_mul_accept", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        repeat (4) cyc();
        setOp(4'd0, 16'h0001, 16'h0001); in_valid = 1'b1; flush = 1'b1;
        #1;
        check("fl_in_ready_during", 32'(in_ready), 32'd0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("fl_out_valid_after", 32'(out_valid), 32'd0);
        check("fl_in_ready_after", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (out_valid) seen++;
        end
        check("fl_no_late_result", 32'(seen), 32'd0);

        // Flush while a result is held and a new op is offered: both discarded.
        cyc();
        setOp(4'd0, 16'h0001, 16'h0001); in_valid = 1'b1; out_ready = 1'b0;
        cyc();
        flush = 1'b1;
        #1;
        check("flh_held_valid", 32'(out_valid), 32'd1);
        check("flh_in_ready", 32'(in_ready), 32'd0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("flh_killed", 32'(out_valid), 32'd0);
        cyc();
        check("flh_op_ignored", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // Asynchronous reset mid-multiply, asserted away from any clock edge.
        cyc();
        setOp(4'd8, 16'h00FF, 16'h00FF); in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_result", 32'(out_result), 32'd0);
        cyc();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (out_valid || !in_ready) seen++;
        end
        check("arst_stays_idle", 32'(seen), 32'd0);

        // Randomized run against the transaction model.
        doReset();
        opList = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
        corner = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        mValid = 1'b0; pend = 1'b0; busyEnd = -1; pendAt = -1;
        mRes = '0; mTgt = '0; mFl = '0; pRes = '0; pTgt = '0; pFl = '0;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 40) == 0);
            in_op      = opList[$urandom_range(0, 10)];
            in_src0    = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            in_reg2    = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            in_imm     = 16'($urandom);
            in_pc      = 16'($urandom);
            in_alu_src = 1'($urandom);
            in_sh      = 4'($urandom);
            in_off     = 9'($urandom);
            in_is_jr   = (in_op == 4'd8) ? 1'b0 : 1'($urandom);
            in_flags   = 3'($urandom);
            #1;
            expReady = (t > busyEnd) && (!mValid || out_ready) && !flush;
            check("rnd_in_ready", 32'(in_ready), 32'(expReady));
            check("rnd_out_valid", 32'(out_valid), 32'(mValid));
            if (mValid && out_valid) begin
                check("rnd_result", 32'(out_result), 32'(mRes));
                check("rnd_flags", 32'(out_flags), 32'(mFl));
                check("rnd_target", 32'(out_target), 32'(mTgt));
            end
            if (flush) begin
                mValid  = 1'b0;
                pend    = 1'b0;
                busyEnd = t;
            end else begin
                if (mValid && out_ready) mValid = 1'b0;
                if (expReady && in_valid) begin
                    bOp = in_alu_src ? in_reg2 : in_imm;
                    refExec(in_op, in_src0, bOp, in_pc, in_sh, in_off, in_is_jr, in_flags, rRes, rFl, rTgt);
                    if (in_op == 4'd8) begin
                        pend = 1'b1; pendAt = t + 17; busyEnd = t + 16;
                        pRes = rRes; pFl = rFl; pTgt = rTgt;
                    end else begin
                        mValid = 1'b1; mRes = rRes; mFl = rFl; mTgt = rTgt;
                    end
                end
                if (pend && (t + 1 == pendAt)) begin
                    mValid = 1'b1; mRes = pRes; mFl = pFl; mTgt = pTgt;
                    pend = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
